// File: rtl/axi4l_pkg.sv
// Shared state encoding, response codes and default widths for the AXI4-Lite master arbiter.
package axi4l_pkg;

    localparam int unsigned DEF_NUM_REQ        = 2;
    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        DONE
    } arb_state_t;

endpackage

// File: rtl/axi4l_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   grant_idx_c,
    output logic               any_c
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant_c[idx[IDX_W-1:0]]  = 1'b1;
                grant_idx_c              = idx[IDX_W-1:0];
            end
        end
    end

    assign any_c = |req;

endmodule

// File: rtl/axi4l_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among NUM_REQ single-beat requesters.
// Optional watchdog: define AXI4L_ARB_TIMEOUT_EN to abort stalled transactions with SLVERR.
module axi4l_master_arbiter
    import axi4l_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [ADDR_W-1:0]             AWADDR,
    output logic                          WVALID,
    input  logic                          WREADY,
    output logic [DATA_W-1:0]             WDATA,
    output logic [DATA_W/8-1:0]           WSTRB,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic [1:0]                    BRESP,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_W-1:0]             ARADDR,
    input  logic                          RVALID,
    output logic                          RREADY,
    input  logic [DATA_W-1:0]             RDATA,
    input  logic [1:0]                    RRESP
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("axi4l_master_arbiter: unsupported parameter set");
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;

    logic [NUM_REQ-1:0]   gnt_c;
    logic [IDX_W-1:0]     gnt_idx_c;
    logic                 gnt_any_c;

`ifdef AXI4L_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    logic [TMR_W-1:0]     timer_q, timer_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant_c     (gnt_c),
        .grant_idx_c (gnt_idx_c),
        .any_c       (gnt_any_c)
    );

    // Next-state and next-output decode; every output is taken from a register.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
`ifdef AXI4L_ARB_TIMEOUT_EN
        timer_d     = '0;
`endif

        case (state_q)
            IDLE: begin
                if (gnt_any_c) begin
                    req_ready_d = gnt_c;
                    owner_d     = gnt_c;
                    addr_d      = req_addr[ADDR_W*32'(gnt_idx_c) +: ADDR_W];
                    wdata_d     = req_wdata[DATA_W*32'(gnt_idx_c) +: DATA_W];
                    wstrb_d     = req_wstrb[STRB_W*32'(gnt_idx_c) +: STRB_W];
                    ptr_d       = (32'(gnt_idx_c) == NUM_REQ - 1) ? '0 : gnt_idx_c + IDX_W'(1);
                    if (req_write[gnt_idx_c]) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // AW and W complete independently; leave only when both have handshaken.
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = BRESP;
                    state_d     = DONE;
                end
            end
            RD_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end
            end
            RD_R: begin
                if (RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = owner_q;
                    rsp_rdata_d = RDATA;
                    rsp_resp_d  = RRESP;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI4L_ARB_TIMEOUT_EN
        // Watchdog: a real handshake this cycle wins over an expiring count.
        if ((state_q inside {WR_AW_W, WR_B, RD_AR, RD_R}) && (state_d == state_q)) begin
            if (32'(timer_q) == TIMEOUT_CYCLES - 1) begin
                state_d     = DONE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = owner_q;
                rsp_rdata_d = '0;
                rsp_resp_d  = RESP_SLVERR;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

`ifdef AXI4L_ARB_TIMEOUT_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // The latched address feeds both address channels; only the matching VALID qualifies it.
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = addr_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = addr_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi4l_master_arbiter.sv
// Directed bench for axi4l_master_arbiter with a small configurable AXI4-Lite slave model.
module tb_axi4l_master_arbiter;

    localparam int unsigned NUM_REQ        = 2;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned STRB_W         = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic                        ACLK = 1'b0;
    logic                        ARESETN = 1'b0;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata = '0;
    logic [NUM_REQ*STRB_W-1:0]   req_wstrb = '0;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [1:0]                  rsp_resp;
    logic                        AWVALID, AWREADY = 1'b0;
    logic [ADDR_W-1:0]           AWADDR;
    logic                        WVALID, WREADY = 1'b0;
    logic [DATA_W-1:0]           WDATA;
    logic [STRB_W-1:0]           WSTRB;
    logic                        BVALID = 1'b0, BREADY;
    logic [1:0]                  BRESP = 2'b00;
    logic                        ARVALID, ARREADY = 1'b0;
    logic [ADDR_W-1:0]           ARADDR;
    logic                        RVALID = 1'b0, RREADY;
    logic [DATA_W-1:0]           RDATA = '0;
    logic [1:0]                  RRESP = 2'b00;

    axi4l_master_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Slave configuration knobs
    int          aw_delay  = 0;
    int          w_delay   = 0;
    logic        b_stall   = 1'b0;
    logic        r_enable  = 1'b1;
    logic [1:0]  bresp_cfg = 2'b00;

    // Slave state and observation counters
    int          aw_wait = 0, w_wait = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, b_active = 1'b0, r_active = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] mem [0:15];
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_valid_cycles = 0, w_valid_cycles = 0, rready_cycles = 0;
    logic        aw_pend = 1'b0, aw_addr_moved = 1'b0;
    logic [31:0] aw_addr_prev = '0;
    int          rsp_cnt [NUM_REQ];
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_resp = '0;
    int          grants [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_expired(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed no event within cycle budget, expected event", tag);
    endtask

    task automatic clear_stats();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_valid_cycles = 0; w_valid_cycles = 0; rready_cycles = 0;
        aw_addr_moved = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rsp_cnt[i] = 0;
        grants.delete();
    endtask

    // Slave handshakes and monitors, sampled at the active edge before the DUT updates.
    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_wait = 0; w_wait = 0;
            aw_got = 1'b0; w_got = 1'b0; b_active = 1'b0; r_active = 1'b0;
            aw_pend = 1'b0;
        end else begin
            if (AWVALID) aw_valid_cycles++;
            if (WVALID)  w_valid_cycles++;
            if (RREADY)  rready_cycles++;
            if (aw_pend && (!AWVALID || AWADDR !== aw_addr_prev)) aw_addr_moved = 1'b1;
            aw_pend      = AWVALID && !AWREADY;
            aw_addr_prev = AWADDR;

            if (AWVALID && AWREADY) begin
                aw_hs++; aw_got = 1'b1; s_awaddr = AWADDR; aw_wait = 0;
            end else if (AWVALID) begin
                aw_wait++;
            end
            if (WVALID && WREADY) begin
                w_hs++; w_got = 1'b1; s_wdata = WDATA; s_wstrb = WSTRB; w_wait = 0;
            end else if (WVALID) begin
                w_wait++;
            end
            if (BVALID && BREADY) begin
                b_hs++; b_active = 1'b0;
            end
            if (aw_got && w_got && !b_active && !b_stall) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[5:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
                aw_got = 1'b0; w_got = 1'b0; b_active = 1'b1;
            end
            if (RVALID && RREADY) begin
                r_hs++; r_active = 1'b0;
            end
            if (ARVALID && ARREADY) begin
                ar_hs++; s_araddr = ARADDR;
                if (r_enable) r_active = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid[i]) begin
                    rsp_cnt[i]++; last_rdata = rsp_rdata; last_resp = rsp_resp;
                end
                if (req_ready[i]) grants.push_back(i);
            end
        end
    end

    // Slave drives its outputs on the falling edge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
            ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        end else begin
            AWREADY = AWVALID && !aw_got && (aw_wait >= aw_delay);
            WREADY  = WVALID && !w_got && (w_wait >= w_delay);
            BVALID  = b_active;
            BRESP   = bresp_cfg;
            ARREADY = ARVALID;
            RVALID  = r_active;
            RDATA   = r_active ? mem[s_araddr[5:2]] : 32'h0;
            RRESP   = 2'b00;
        end
    end

    task automatic start_cmd(input int idx, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb, input string tag);
        req_write[idx]            = wr;
        req_addr[idx*32 +: 32]    = addr;
        req_wdata[idx*32 +: 32]   = data;
        req_wstrb[idx*4 +: 4]     = strb;
        req_valid[idx]            = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge ACLK);
            if (req_ready[idx]) begin
                req_valid[idx] = 1'b0;
                return;
            end
        end
        req_valid[idx] = 1'b0;
        bound_expired(tag);
    endtask

    task automatic wait_rsp(input int idx, input string tag);
        for (int c = 0; c < 100; c++) begin
            @(negedge ACLK);
            if (rsp_valid[idx]) return;
        end
        bound_expired(tag);
    endtask

    initial begin
        int          issued [NUM_REQ];
        logic [5:0]  order;
        logic        done;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        clear_stats();

        // Reset state
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        check("reset_ctrl", {req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'h0);
        check("reset_addr", {AWADDR, ARADDR}, 64'h0);
        check("reset_rsp", {rsp_rdata, rsp_resp}, 64'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Requester 0 writes 0x4 <- 0xDEADBEEF, zero-wait slave
        clear_stats();
        start_cmd(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, "t1_ready");
        wait_rsp(0, "t1_rsp");
        check("t1_resp", rsp_resp, 64'h0);
        check("t1_rdata", rsp_rdata, 64'h0);
        @(negedge ACLK);
        check("t1_rsp_pulse", rsp_valid, 64'h0);
        check("t1_grant_cnt", grants.size(), 64'd1);
        check("t1_grant_idx", grants[0], 64'd0);
        check("t1_aw_w_hs", {aw_hs[7:0], w_hs[7:0]}, 64'h0101);
        check("t1_slave_addr", s_awaddr, 64'h4);
        check("t1_slave_data", {s_wstrb, s_wdata}, 64'hF_DEADBEEF);
        check("t1_rsp_cnt", {rsp_cnt[1][7:0], rsp_cnt[0][7:0]}, 64'h0001);

        // Requester 1 reads 0x4
        clear_stats();
        start_cmd(1, 1'b0, 32'h4, 32'h0, 4'h0, "t2_ready");
        wait_rsp(1, "t2_rsp");
        check("t2_rdata", rsp_rdata, 64'hDEADBEEF);
        check("t2_resp", rsp_resp, 64'h0);
        @(negedge ACLK);
        check("t2_araddr", s_araddr, 64'h4);
        check("t2_ar_hs", ar_hs, 64'd1);
        check("t2_rsp_cnt", {rsp_cnt[1][7:0], rsp_cnt[0][7:0]}, 64'h0100);

        // Both requesters valid from reset, three commands each
        ARESETN = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        clear_stats();
        issued[0] = 0;
        issued[1] = 0;
        req_write = 2'b01;
        req_addr  = {32'h20, 32'h20};
        req_wdata = {32'h0, 32'h100};
        req_wstrb = {4'h0, 4'hF};
        req_valid = 2'b11;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge ACLK);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    issued[i]++;
                    if (issued[i] == 3) req_valid[i] = 1'b0;
                    else if (i == 0) req_wdata[31:0] = 32'h100 + 32'(issued[0]);
                end
            end
            if (rsp_cnt[0] + rsp_cnt[1] == 6) done = 1'b1;
        end
        req_valid = '0;
        if (!done) bound_expired("t3_complete");
        order = '0;
        for (int k = 0; k < 6; k++) if (k < grants.size()) order[k] = grants[k][0];
        check("t3_grant_cnt", grants.size(), 64'd6);
        check("t3_grant_order", order, 64'b101010);
        check("t3_rsp_cnt", {rsp_cnt[1][7:0], rsp_cnt[0][7:0]}, 64'h0303);
        check("t3_last_read", last_rdata, 64'h102);

        // AWREADY delayed 3 cycles, WREADY immediate
        clear_stats();
        aw_delay = 3;
        start_cmd(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'h3, "t4_ready");
        wait_rsp(0, "t4_rsp");
        @(negedge ACLK);
        aw_delay = 0;
        check("t4_awvalid_cycles", aw_valid_cycles, 64'd4);
        check("t4_wvalid_cycles", w_valid_cycles, 64'd1);
        check("t4_awaddr_stable", aw_addr_moved, 64'h0);
        check("t4_hs", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 64'h010101);
        check("t4_rsp_cnt", rsp_cnt[0], 64'd1);
        check("t4_mem_strobe", mem[12], 64'h0000F00D);

        // Reset asserted while waiting for the write response
        clear_stats();
        b_stall = 1'b1;
        start_cmd(1, 1'b1, 32'h8, 32'h12345678, 4'hF, "t5_ready");
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge ACLK);
            if (BREADY) done = 1'b1;
        end
        if (!done) bound_expired("t5_reach_wr_b");
        #1 ARESETN = 1'b0;
        #1;
        check("t5_reset_ctrl", {req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'h0);
        check("t5_reset_wr", {AWADDR, WDATA}, 64'h0);
        check("t5_reset_misc", {WSTRB, ARADDR, rsp_resp}, 64'h0);
        check("t5_reset_rdata", rsp_rdata, 64'h0);
        b_stall = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        check("t5_no_rsp", {rsp_cnt[1][7:0], rsp_cnt[0][7:0]}, 64'h0);
        start_cmd(1, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, "t5_ready2");
        wait_rsp(1, "t5_rsp2");
        check("t5_resp2", rsp_resp, 64'h0);
        @(negedge ACLK);
        check("t5_rsp_cnt2", rsp_cnt[1], 64'd1);
        check("t5_mem", mem[2], 64'h0BADF00D);

        // Slave error response passes through to the requester
        bresp_cfg = 2'b10;
        start_cmd(0, 1'b1, 32'hC, 32'h55AA55AA, 4'hF, "t6_ready");
        wait_rsp(0, "t6_rsp");
        check("t6_slverr", rsp_resp, 64'h2);
        @(negedge ACLK);
        bresp_cfg = 2'b00;

`ifdef AXI4L_ARB_TIMEOUT_EN
        // Read data never arrives; watchdog completes with SLVERR
        clear_stats();
        r_enable = 1'b0;
        start_cmd(0, 1'b0, 32'h4, 32'h0, 4'h0, "t7_ready");
        wait_rsp(0, "t7_rsp");
        check("t7_resp", rsp_resp, 64'h2);
        check("t7_rdata", rsp_rdata, 64'h0);
        @(negedge ACLK);
        check("t7_rready_cycles", rready_cycles, 64'd16);
        check("t7_axi_idle", {ARVALID, RREADY, AWVALID, WVALID, BREADY}, 64'h0);
        r_enable = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
